traffic_junction: RTL

//  Parametrised UK junction controller: N_ARMS approaches sequenced red -> red+amber -> green -> amber -> red.
//  At most one arm is non-red at a time, with an all-red clearance between arms.

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/traffic_rr_pick.sv | 31 +++
 rtl/traffic_junction.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encodings and per-phase lamp patterns for the junction controller.
// The pedestrian phase is only reachable when PED_REQ_EN is defined.
package traffic_pkg;

  typedef logic [2:0] phase_t;

  localparam logic [2:0] ALL_RED   = 3'd0;
  localparam logic [2:0] RED_AMBER = 3'd1;
  localparam logic [2:0] GREEN     = 3'd2;
  localparam logic [2:0] AMBER     = 3'd3;
  localparam logic [2:0] PED_WALK  = 3'd4;

  typedef struct packed {
    logic r;
    logic a;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_ALL_RED   = 3'b100;
  localparam lamp_t LAMP_RED_AMBER = 3'b110;
  localparam lamp_t LAMP_GREEN     = 3'b001;
  localparam lamp_t LAMP_AMBER     = 3'b010;
  localparam lamp_t LAMP_PED_WALK  = 3'b100;

  // Lamp pattern shown on the active arm; unknown encodings fail safe to red.
  function automatic lamp_t lamp_of(input phase_t ph);
    lamp_t l;
    case (ph)
      RED_AMBER: l = LAMP_RED_AMBER;
      GREEN:     l = LAMP_GREEN;
      AMBER:     l = LAMP_AMBER;
      PED_WALK:  l = LAMP_PED_WALK;
      default:   l = LAMP_ALL_RED;
    endcase
    return l;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin next-arm picker: first requesting arm after cur (wrapping, cur last);
// with no demand at all it simply advances to cur+1.
module traffic_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next_arm,
  output logic         any_req
);

  typedef logic [W:0] sum_t;
  localparam sum_t N_L = sum_t'(N);

  sum_t sum;

  // Scan from the farthest offset down so the nearest requesting arm wins.
  always_comb begin
    any_req = |req;
    sum     = {1'b0, cur} + sum_t'(1);
    if (sum >= N_L) sum = sum - N_L;
    next_arm = sum[W-1:0];
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, cur} + sum_t'(k);
      if (sum >= N_L) sum = sum - N_L;
      if (req[sum[W-1:0]]) next_arm = sum[W-1:0];
    end
  end

endmodule

// File: rtl/traffic_junction.sv
// UK junction controller: one arm at a time through RA -> G -> A with all-red clearance.
// Optional pedestrian walk phase is built when PED_REQ_EN is defined.
module traffic_junction
  import traffic_pkg::*;
#(
  parameter int N_ARMS      = 4,
  parameter int T_ALLRED    = 2,
  parameter int T_RED_AMBER = 2,
  parameter int T_GREEN     = 4,
  parameter int T_GREEN_MAX = 8,
  parameter int T_AMBER     = 3,
  parameter int T_PED       = 6,
  localparam int ARM_W      = (N_ARMS > 1) ? $clog2(N_ARMS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ARMS-1:0] car_req,
  input  logic              fault,
`ifdef PED_REQ_EN
  input  logic              ped_req,
  output logic              ped_walk,
`endif
  output logic [N_ARMS-1:0] red,
  output logic [N_ARMS-1:0] amber,
  output logic [N_ARMS-1:0] green,
  output logic [ARM_W-1:0]  active_arm,
  output logic [2:0]        phase
);

  localparam int T_MAX = max_int(max_int(max_int(T_ALLRED, T_RED_AMBER),
                                         max_int(T_GREEN_MAX, T_AMBER)), T_PED);
  localparam int CNT_W = $clog2(T_MAX) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t C_ALLRED = cnt_t'(T_ALLRED - 1);
  localparam cnt_t C_RA     = cnt_t'(T_RED_AMBER - 1);
  localparam cnt_t C_GREEN  = cnt_t'(T_GREEN - 1);
  localparam cnt_t C_GMAX   = cnt_t'(T_GREEN_MAX - 1);
  localparam cnt_t C_AMBER  = cnt_t'(T_AMBER - 1);
  localparam cnt_t C_PED    = cnt_t'(T_PED - 1);

  phase_t           phase_reg, phase_next;
  logic [ARM_W-1:0] arm_reg, arm_next;
  cnt_t             cnt_reg, cnt_next;
  cnt_t             age_reg, age_next;
  logic             ped_pending;
  logic [ARM_W-1:0] rr_next;
  logic             any_req;
  logic             cnt_zero, age_zero, own_req, conflict;

  traffic_rr_pick #(.N(N_ARMS), .W(ARM_W)) u_pick (
    .req      (car_req),
    .cur      (arm_reg),
    .next_arm (rr_next),
    .any_req  (any_req)
  );

  assign cnt_zero = (cnt_reg == '0);
  assign age_zero = (age_reg == '0);
  assign own_req  = car_req[arm_reg];
  // The picker only lands back on the active arm when that arm is the sole requester.
  assign conflict = (any_req && (rr_next != arm_reg)) || ped_pending;

  always_comb begin
    phase_next = phase_reg;
    arm_next   = arm_reg;
    cnt_next   = cnt_zero ? cnt_reg : cnt_reg - 1'b1;
    age_next   = age_zero ? age_reg : age_reg - 1'b1;
    case (phase_reg)
      ALL_RED: begin
        if (fault) begin
          cnt_next = C_ALLRED;
        end else if (cnt_zero) begin
          phase_next = RED_AMBER;
          arm_next   = rr_next;
          cnt_next   = C_RA;
        end
      end
      RED_AMBER: begin
        if (fault) begin
          phase_next = ALL_RED;
          cnt_next   = C_ALLRED;
        end else if (cnt_zero) begin
          phase_next = GREEN;
          cnt_next   = C_GREEN;
          age_next   = C_GMAX;
        end
      end
      GREEN: begin
        // Own-arm demand extends the green up to the maximum age.
        if (fault || (cnt_zero && conflict && (!own_req || age_zero))) begin
          phase_next = AMBER;
          cnt_next   = C_AMBER;
        end
      end
      AMBER: begin
        if (cnt_zero) begin
          if (ped_pending && !fault) begin
            phase_next = PED_WALK;
            cnt_next   = C_PED;
          end else begin
            phase_next = ALL_RED;
            cnt_next   = C_ALLRED;
          end
        end
      end
      PED_WALK: begin
        if (fault || cnt_zero) begin
          phase_next = ALL_RED;
          cnt_next   = C_ALLRED;
        end
      end
      default: begin
        phase_next = ALL_RED;
        cnt_next   = C_ALLRED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= ALL_RED;
      arm_reg   <= '0;
      cnt_reg   <= C_ALLRED;
      age_reg   <= C_GMAX;
    end else begin
      phase_reg <= phase_next;
      arm_reg   <= arm_next;
      cnt_reg   <= cnt_next;
      age_reg   <= age_next;
    end
  end

`ifdef PED_REQ_EN
  logic ped_pending_reg;

  // A new request wins over the clear, so a press during the walk is kept for next round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending_reg <= 1'b0;
    end else if (ped_req) begin
      ped_pending_reg <= 1'b1;
    end else if (phase_next == PED_WALK && phase_reg != PED_WALK) begin
      ped_pending_reg <= 1'b0;
    end
  end

  assign ped_pending = ped_pending_reg;
  assign ped_walk    = (phase_reg == PED_WALK);
`else
  assign ped_pending = 1'b0;
`endif

  lamp_t lamp;
  assign lamp       = lamp_of(phase_reg);
  assign active_arm = arm_reg;
  assign phase      = phase_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_ARMS; gi++) begin : g_arm
      logic sel;
      assign sel       = (arm_reg == ARM_W'(gi));
      assign red[gi]   = sel ? lamp.r : 1'b1;
      assign amber[gi] = sel ? lamp.a : 1'b0;
      assign green[gi] = sel ? lamp.g : 1'b0;
    end
  endgenerate

endmodule
